// File: rtl/mio_bus_arbiter.sv
// mio_bus_arbiter: round-robin sharing of the single MIO bus between two masters,
// with a fixed wait window per transaction and a one-cycle ack pulse.
module mio_bus_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_mem_w,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy,
    output logic              grant_id
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              last_q, gid_q, we_q, m0_ack_q, m1_ack_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, m0_rdata_q, m1_rdata_q;
    logic              win_d;
    // A lone requester always wins; under contention the loser of the last grant wins.
    assign win_d = (m0_req && m1_req) ? ~last_q : m1_req;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= 1'b1;
            gid_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (m0_req || m1_req) begin
                    state_q <= BUSY;
                    gid_q   <= win_d;
                    last_q  <= win_d;
                    cnt_q   <= 4'(WAIT_CYCLES);
                    we_q    <= win_d ? m1_we : m0_we;
                    addr_q  <= win_d ? m1_addr : m0_addr;
                    wdata_q <= win_d ? m1_wdata : m0_wdata;
                end
                BUSY: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        // Latched values double as bus drivers, so clearing them releases the bus.
                        state_q  <= RESP;
                        we_q     <= 1'b0;
                        addr_q   <= '0;
                        wdata_q  <= '0;
                        m0_ack_q <= ~gid_q;
                        m1_ack_q <= gid_q;
                        if (gid_q) m1_rdata_q <= bus_rdata;
                        else       m0_rdata_q <= bus_rdata;
                    end
                end
                RESP: begin
                    state_q  <= IDLE;
                    m0_ack_q <= 1'b0;
                    m1_ack_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus_addr  = addr_q;
    assign bus_mem_w = we_q;
    assign bus_wdata = wdata_q;
    assign busy      = state_q != IDLE;
    assign grant_id  = gid_q;
    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
endmodule

// File: tb/tb_mio_bus_arbiter.sv
// tb_mio_bus_arbiter: directed and randomized transactions checked against a
// transaction-level model of the arbiter (round-robin winner, fixed wait window).
module tb_mio_bus_arbiter;
    localparam int W = 2;
    logic        clk = 0, rst = 1;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0, bus_rdata = 0;
    logic        m0_ack, m1_ack, bus_mem_w, busy, grant_id;
    logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;
    logic        s_req = 0, s_ack0, s_ack1, s_mem_w, s_busy, s_gid;
    logic [31:0] s_addr = 0, s_rdata_in = 0, s_rdata0, s_rdata1, s_bus_addr, s_bus_wdata;
    int          checks = 0, errors = 0;
    logic        last_g;
    logic        rd_valid [2];
    logic [31:0] exp_rd [2];

    always #5 clk = ~clk;

    mio_bus_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .bus_addr(bus_addr), .bus_mem_w(bus_mem_w), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .busy(busy), .grant_id(grant_id)
    );

    mio_bus_arbiter #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .m0_req(s_req), .m0_we(1'b0), .m0_addr(s_addr), .m0_wdata(32'h0),
        .m0_ack(s_ack0), .m0_rdata(s_rdata0),
        .m1_req(1'b0), .m1_we(1'b0), .m1_addr(32'h0), .m1_wdata(32'h0),
        .m1_ack(s_ack1), .m1_rdata(s_rdata1),
        .bus_addr(s_bus_addr), .bus_mem_w(s_mem_w), .bus_wdata(s_bus_wdata),
        .bus_rdata(s_rdata_in), .busy(s_busy), .grant_id(s_gid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " mem_w"}, bus_mem_w, 0);
        chk({tag, " bus_addr"}, bus_addr, 0);
        chk({tag, " bus_wdata"}, bus_wdata, 0);
        chk({tag, " acks"}, {m0_ack, m1_ack}, 0);
    endtask

    // One complete transaction from an IDLE cycle; scr=1 scrambles inputs randomly
    // during the wait window, scr=2 retargets m0 and drops its request.
    task automatic txn(input logic r0, r1, w0, w1, input logic [31:0] a0, d0, a1, d1, rd,
                       input int scr);
        logic        w, ewe;
        logic [31:0] ea, ed;
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        bus_rdata = rd;
        w   = (r0 && r1) ? !last_g : r1;
        ewe = w ? w1 : w0;
        ea  = w ? a1 : a0;
        ed  = w ? d1 : d0;
        last_g = w;
        step();
        for (int i = 0; i < W; i++) begin
            chk("busy in wait", busy, 1);
            chk("bus_addr", bus_addr, ea);
            chk("bus_mem_w", bus_mem_w, ewe);
            chk("bus_wdata", bus_wdata, ed);
            chk("grant_id", grant_id, w);
            chk("no ack in wait", {m0_ack, m1_ack}, 0);
            if (scr == 1) begin
                m0_req = 1'($urandom); m0_we = 1'($urandom); m0_addr = $urandom; m0_wdata = $urandom;
                m1_req = 1'($urandom); m1_we = 1'($urandom); m1_addr = $urandom; m1_wdata = $urandom;
            end else if (scr == 2) begin
                m0_req = 0; m0_addr = 32'hF000_0000;
            end
            step();
        end
        chk("m0_ack", m0_ack, !w);
        chk("m1_ack", m1_ack, w);
        chk("busy in resp", busy, 1);
        chk("mem_w in resp", bus_mem_w, 0);
        chk("bus_addr in resp", bus_addr, 0);
        if (!ewe) begin
            chk("winner rdata", w ? m1_rdata : m0_rdata, rd);
            rd_valid[w] = 1; exp_rd[w] = rd;
        end else rd_valid[w] = 0;
        if (rd_valid[!w]) chk("other rdata held", w ? m0_rdata : m1_rdata, exp_rd[!w]);
        step();
        chk_quiet("idle after resp");
        chk("grant_id held", grant_id, w);
    endtask

    initial begin
        last_g = 1;
        rd_valid[0] = 1; rd_valid[1] = 1; exp_rd[0] = 0; exp_rd[1] = 0;
        step();
        step();
        chk_quiet("reset");
        chk("reset grant_id", grant_id, 0);
        chk("reset rdata", {m0_rdata, m1_rdata}, 0);
        rst = 0;
        step();
        chk_quiet("idle no req");

        txn(1, 0, 0, 0, 32'h10, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 0);
        txn(0, 1, 0, 1, 32'h0, 32'h0, 32'hE000_0000, 32'h1234_5678, 32'h5555_AAAA, 0);
        for (int i = 0; i < 4; i++)
            txn(1, 1, 0, 0, 32'h100 + i, 0, 32'h200 + i, 0, 32'hC0DE_0000 + i, 0);
        txn(1, 0, 1, 0, 32'h4, 32'hABCD_0001, 32'h0, 32'h0, 32'h0, 2);

        m0_req = 1; m1_req = 0; m0_we = 1; m0_addr = 32'h8; m0_wdata = 32'h77;
        step();
        chk("busy before abort", busy, 1);
        rst = 1; m0_req = 0;
        step();
        chk_quiet("abort");
        rst = 0;
        last_g = 1;
        rd_valid[0] = 1; rd_valid[1] = 1; exp_rd[0] = 0; exp_rd[1] = 0;
        step();
        chk_quiet("after abort");
        txn(1, 1, 0, 0, 32'h30, 0, 32'h40, 0, 32'h1111_2222, 0);
        txn(1, 1, 0, 0, 32'h50, 0, 32'h60, 0, 32'h3333_4444, 0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] rq;
            rq = 2'($urandom_range(1, 3));
            txn(rq[0], rq[1], 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom,
                $urandom, int'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                m0_req = 0; m1_req = 0;
                step();
                chk_quiet("random idle");
            end
        end

        s_req = 1; s_addr = 32'hF000_0000; s_rdata_in = 32'h0000_00FF;
        step();
        chk("w1 busy", s_busy, 1);
        chk("w1 bus_addr", s_bus_addr, 32'hF000_0000);
        chk("w1 mem_w", s_mem_w, 0);
        chk("w1 no early ack", s_ack0, 0);
        s_req = 0;
        step();
        chk("w1 ack", {s_ack0, s_ack1}, 2'b10);
        chk("w1 rdata", s_rdata0, 32'hFF);
        chk("w1 bus released", s_bus_addr, 0);
        step();
        chk("w1 idle", {s_busy, s_ack0}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
